// File: rtl/seg7_hex_display.sv
// Multi-digit hex 7-segment driver: valid/ready shadow capture, leading-zero blanking,
// per-digit blink and global PWM dimming, all folded into one registered active-low output.

module seg7_digit (
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  input  logic       i_off,
  output logic [7:0] o_seg
);
  logic [6:0] w_gly;

  always_comb begin
    w_gly = 7'h7F;
    case (i_nib)
      4'h0: w_gly = 7'h40;
      4'h1: w_gly = 7'h79;
      4'h2: w_gly = 7'h24;
      4'h3: w_gly = 7'h30;
      4'h4: w_gly = 7'h19;
      4'h5: w_gly = 7'h12;
      4'h6: w_gly = 7'h02;
      4'h7: w_gly = 7'h78;
      4'h8: w_gly = 7'h00;
      4'h9: w_gly = 7'h18;
      4'hA: w_gly = 7'h08;
      4'hB: w_gly = 7'h03;
      4'hC: w_gly = 7'h46;
      4'hD: w_gly = 7'h21;
      4'hE: w_gly = 7'h06;
      4'hF: w_gly = 7'h0E;
      default: w_gly = 7'h7F;
    endcase
  end

  // PWM/blink off kills DP too; leading-zero blank keeps the DP
  always_comb begin
    o_seg = {~i_dp, w_gly};
    if (i_off)        o_seg = 8'hFF;
    else if (i_blank) o_seg = {~i_dp, 7'h7F};
  end
endmodule

module seg7_hex_display #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int PWM_BITS  = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iVALID,
  input  logic [4*DIGITS-1:0]   iDATA,
  input  logic [DIGITS-1:0]     iDP,
  input  logic [DIGITS-1:0]     iBLINK,
  input  logic                  iLZB,
  input  logic [PWM_BITS-1:0]   iBRIGHT,
  output logic [8*DIGITS-1:0]   oSEG,
  output logic                  oREADY
);
  localparam int BW = $clog2(BLINK_DIV);

  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp, r_blink;
  logic                r_lzb;
  logic [PWM_BITS-1:0] r_bright, r_pwm;
  logic [BW-1:0]       r_bcnt;
  logic                r_phase, r_rdy;
  logic [8*DIGITS-1:0] r_seg;

  logic                w_xfer, w_lit;
  logic [DIGITS:0]     w_hz;
  logic [DIGITS-1:0]   w_blank, w_off;
  logic [8*DIGITS-1:0] w_seg;

  // iRST gates ready combinationally so a mid-run reset refuses the transfer in its own cycle
  assign oREADY = r_rdy & ~iRST;
  assign w_xfer = iVALID & oREADY;
  assign w_lit  = (r_pwm < r_bright) | (&r_bright);
  assign oSEG   = r_seg;

  // w_hz[k]: nibbles k..DIGITS-1 are all zero
  assign w_hz[DIGITS] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_hz[g]  = w_hz[g+1] & (r_data[4*g +: 4] == 4'h0);
    if (g == 0) begin : g_lsd
      assign w_blank[g] = 1'b0;
    end else begin : g_upper
      assign w_blank[g] = r_lzb & w_hz[g];
    end
    assign w_off[g] = ~w_lit | (r_blink[g] & r_phase);

    seg7_digit u_dig (
      .i_nib   (r_data[4*g +: 4]),
      .i_dp    (r_dp[g]),
      .i_blank (w_blank[g]),
      .i_off   (w_off[g]),
      .o_seg   (w_seg[8*g +: 8])
    );
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_data   <= '0;
      r_dp     <= '0;
      r_blink  <= '0;
      r_lzb    <= 1'b0;
      r_bright <= '0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
      r_pwm    <= '0;
      r_rdy    <= 1'b0;
      r_seg    <= '1;
    end else begin
      r_rdy <= 1'b1;
      r_seg <= w_seg;
      r_pwm <= r_pwm + 1'b1;
      if (r_bcnt == BW'(BLINK_DIV - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
      if (w_xfer) begin
        r_data   <= iDATA;
        r_dp     <= iDP;
        r_blink  <= iBLINK;
        r_lzb    <= iLZB;
        r_bright <= iBRIGHT;
      end
    end
  end
endmodule

// File: tb/tb_seg7_hex_display.sv
// Randomized bench for seg7_hex_display against an arithmetic reference model
// (counters derived from the number of edges since reset).

module tb_seg7_hex_display;
  localparam int D  = 6;
  localparam int BD = 4;
  localparam int PB = 2;

  logic          iCLK = 1'b0;
  logic          iRST, iVALID, iLZB;
  logic [4*D-1:0] iDATA;
  logic [D-1:0]  iDP, iBLINK;
  logic [PB-1:0] iBRIGHT;
  logic [8*D-1:0] oSEG;
  logic          oREADY;

  seg7_hex_display #(.DIGITS(D), .BLINK_DIV(BD), .PWM_BITS(PB)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iDATA(iDATA), .iDP(iDP),
    .iBLINK(iBLINK), .iLZB(iLZB), .iBRIGHT(iBRIGHT), .oSEG(oSEG), .oREADY(oREADY)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference state
  logic [4*D-1:0] m_data;
  logic [D-1:0]   m_dp, m_blink;
  logic           m_lzb;
  logic [PB-1:0]  m_br;
  int             m_k;
  bit             m_rdy;
  logic [8*D-1:0] m_seg;

  task automatic chk(input string tag, input logic [8*D-1:0] obs, input logic [8*D-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // display image for the captured state after m_k free-running edges since reset
  function automatic logic [8*D-1:0] ref_seg();
    logic [8*D-1:0] s;
    int hi, phase, pwm;
    bit lit;
    hi = 0;
    for (int d = 0; d < D; d++) if (m_data[4*d +: 4] != 0) hi = d;
    phase = (m_k / BD) % 2;
    pwm   = m_k % (1 << PB);
    lit   = (pwm < int'(m_br)) || (int'(m_br) == (1 << PB) - 1);
    for (int d = 0; d < D; d++) begin
      if (!lit)                         s[8*d +: 8] = 8'hFF;
      else if (m_blink[d] && phase == 1) s[8*d +: 8] = 8'hFF;
      else if (m_lzb && d > hi)         s[8*d +: 8] = {~m_dp[d], 7'h7F};
      else                              s[8*d +: 8] = {~m_dp[d], GLY[m_data[4*d +: 4]]};
    end
    return s;
  endfunction

  task automatic step();
    @(posedge iCLK);
    if (iRST) begin
      m_seg = '1; m_data = '0; m_dp = '0; m_blink = '0; m_lzb = 1'b0; m_br = '0;
      m_k = 0; m_rdy = 1'b0;
    end else begin
      m_seg = ref_seg();
      if (iVALID && m_rdy) begin
        m_data = iDATA; m_dp = iDP; m_blink = iBLINK; m_lzb = iLZB; m_br = iBRIGHT;
      end
      m_k++;
      m_rdy = 1'b1;
    end
    #1;
    chk("seg", oSEG, m_seg);
    chk("rdy", {{(8*D-1){1'b0}}, oREADY}, {{(8*D-1){1'b0}}, (m_rdy && !iRST)});
  endtask

  task automatic xfer(input logic [4*D-1:0] data, input logic [D-1:0] dp,
                      input logic [D-1:0] blink, input logic lzb, input logic [PB-1:0] br);
    iDATA = data; iDP = dp; iBLINK = blink; iLZB = lzb; iBRIGHT = br; iVALID = 1'b1;
    step();
    iVALID = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iVALID = 1'b0; iDATA = '0; iDP = '0; iBLINK = '0; iLZB = 1'b0; iBRIGHT = '0;
    step(); step();
    chk("reset_seg", oSEG, {8*D{1'b1}});
    iRST = 1'b0;
    step();

    // basic glyphs, stable while fully bright
    xfer(24'h0123AF, '0, '0, 1'b0, 2'd3);
    step();
    chk("glyphs", oSEG, 48'hC0F9A4B0888E);
    repeat (5) step();
    chk("glyphs_stable", oSEG, 48'hC0F9A4B0888E);

    // leading-zero blanking
    xfer(24'h0123AF, 6'b100000, '0, 1'b1, 2'd3);
    step();
    chk("lzb_dp", oSEG, 48'h7FF9A4B0888E);
    xfer(24'h000000, '0, '0, 1'b1, 2'd3);
    step();
    chk("lzb_zero", oSEG, 48'hFFFFFFFFFFC0);

    // blink on digit 0, then PWM dimming levels
    xfer(24'h0123AF, '0, 6'b000001, 1'b0, 2'd3);
    repeat (20) step();
    xfer(24'h0123AF, '0, '0, 1'b0, 2'd1);
    repeat (12) step();
    xfer(24'h0123AF, '0, '0, 1'b0, 2'd0);
    repeat (8) step();

    // one-cycle reset mid-display
    xfer(24'h0123AF, '0, '0, 1'b0, 2'd3);
    step();
    iRST = 1'b1;
    step();
    chk("midrst_seg", oSEG, {8*D{1'b1}});
    iRST = 1'b0;
    repeat (4) step();

    // back-to-back transfers
    iVALID = 1'b1; iBRIGHT = 2'd3; iLZB = 1'b0; iDP = '0; iBLINK = '0;
    for (int i = 0; i < 40; i++) begin
      iDATA = 24'(i * 24'h010203);
      step();
    end
    iVALID = 1'b0;
    repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      iRST    = ($urandom_range(0, 63) == 0);
      iVALID  = $urandom_range(0, 1) == 1;
      iDATA   = 24'($urandom >> (4 * $urandom_range(2, 8)));
      iDP     = 6'($urandom);
      iBLINK  = ($urandom_range(0, 1) == 1) ? 6'($urandom) : '0;
      iLZB    = $urandom_range(0, 1) == 1;
      iBRIGHT = 2'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
